pico_port_fifo: RTL and testbench

PICO_PORT_FIFO -- requirements
Module: pico_port_fifo

---
 rtl/pico_port_fifo_if.sv | 35 +++
 rtl/pico_port_fifo.sv | 134 +++++++++++++
 tb/tb_pico_port_fifo.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pico_port_fifo_if.sv
// pico_port_fifo_if: processor port bus, RX producer stream and TX consumer
// stream of pico_port_fifo, grouped as one bundle. Signal names follow the
// original port list so existing processor-side wiring maps one-to-one.
interface pico_port_fifo_if;
  // Processor port bus
  logic [7:0] port_id;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] out_port;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack;
  // RX producer stream
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  // TX consumer stream
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  // Processor, producer and consumer side
  modport master (
    output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    output rx_data, rx_valid, tx_ready,
    input  in_port, interrupt, rx_ready, tx_data, tx_valid
  );

  // Peripheral side
  modport slave (
    input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
    input  rx_data, rx_valid, tx_ready,
    output in_port, interrupt, rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/pico_port_fifo.sv
// pico_port_fifo: three-port processor peripheral.
//   BASE_ADDR+0 : read pops the RX FIFO head (8'h00 when empty)
//   BASE_ADDR+1 : read status {4'b0, tx_valid, interrupt, full, empty};
//                 write control {bit1 flush (self-clearing), bit0 irq_en}
//   BASE_ADDR+2 : write loads the single-byte TX holding register
// The TX path is built only when macro PICO_PORT_TX_EN is defined; without it
// tx_valid/tx_data are tied low and BASE_ADDR+2 writes are ignored.
module pico_port_fifo #(
  parameter logic [7:0]  BASE_ADDR  = 8'h10,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic            clk,
  input  logic            reset,
  pico_port_fifo_if.slave bus
);

  localparam int unsigned            DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [7:0]             ADDR_DATA = BASE_ADDR;
  localparam logic [7:0]             ADDR_CTRL = BASE_ADDR + 8'd1;
  localparam logic [7:0]             ADDR_TX   = BASE_ADDR + 8'd2;
  localparam logic [DEPTH_LOG2-1:0]  PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]    CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]    CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  irq_en_q, irq_en_d;
  logic                  int_q, int_d;
  logic [7:0]            in_port_q, in_port_d;
  logic                  tx_valid_q, tx_valid_d;
  logic [7:0]            tx_data_q, tx_data_d;

  logic full, empty, ctrl_wr, flush, push, pop;

  // Strobe decode; a flush suppresses any push or pop in the same cycle
  always_comb begin
    full    = (count_q == CNT_FULL);
    empty   = (count_q == '0);
    ctrl_wr = bus.write_strobe && (bus.port_id == ADDR_CTRL);
    flush   = ctrl_wr && bus.out_port[1];
    push    = bus.rx_valid && !full && !flush;
    pop     = bus.read_strobe && (bus.port_id == ADDR_DATA) && !empty && !flush;
  end

  // Next-state for FIFO pointers/count, control, interrupt, read mux and TX
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end

    irq_en_d = ctrl_wr ? bus.out_port[0] : irq_en_q;

    // Set has priority over acknowledge
    int_d = int_q;
    if (push && irq_en_q)       int_d = 1'b1;
    else if (bus.interrupt_ack) int_d = 1'b0;

    // Read data reflects state before this edge's pop
    case (bus.port_id)
      ADDR_DATA: in_port_d = empty ? '0 : mem_q[rd_ptr_q];
      ADDR_CTRL: in_port_d = {4'b0000, tx_valid_q, int_q, full, empty};
      default:   in_port_d = '0;
    endcase

`ifdef PICO_PORT_TX_EN
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    if (tx_valid_q && bus.tx_ready) tx_valid_d = 1'b0;
    if (bus.write_strobe && (bus.port_id == ADDR_TX) && !tx_valid_q) begin
      tx_valid_d = 1'b1;
      tx_data_d  = bus.out_port;
    end
`else
    tx_valid_d = 1'b0;
    tx_data_d  = '0;
`endif
  end

`ifndef PICO_PORT_TX_EN
  // Inputs only the TX path consumes
  logic unused_tx_inputs;
  assign unused_tx_inputs = &{1'b0, bus.out_port[7:2], bus.tx_ready};
`endif

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      irq_en_q   <= 1'b0;
      int_q      <= 1'b0;
      in_port_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      irq_en_q   <= irq_en_d;
      int_q      <= int_d;
      in_port_q  <= in_port_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // FIFO storage; contents need no reset since the count gates visibility
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.in_port   = in_port_q;
  assign bus.interrupt = int_q;
  assign bus.rx_ready  = !full;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_valid  = tx_valid_q;

endmodule

// File: tb/tb_pico_port_fifo.sv
// tb_pico_port_fifo: scoreboard bench for pico_port_fifo (BASE 8'h10, depth 16).
// Expected read bytes are queued when a read strobe is driven and compared
// when in_port updates. TX checks follow PICO_PORT_TX_EN.
module tb_pico_port_fifo;

  localparam logic [7:0] BASE  = 8'h10;
  localparam int         DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pico_port_fifo_if bus();

  pico_port_fifo #(.BASE_ADDR(BASE), .DEPTH_LOG2(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_rd_q[$];
  bit         model_irq_en = 1'b0;
  bit         model_int    = 1'b0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.port_id       = '0;
    bus.write_strobe  = 1'b0;
    bus.read_strobe   = 1'b0;
    bus.out_port      = '0;
    bus.rx_valid      = 1'b0;
    bus.rx_data       = '0;
    bus.interrupt_ack = 1'b0;
  endtask

  // One cycle of optional push and optional head read at BASE
  task automatic cycle(input bit do_push, input logic [7:0] d, input bit do_pop);
    bit         was_full;
    logic [7:0] head;
    was_full = (model_q.size() == DEPTH);
    head     = (model_q.size() != 0) ? model_q[0] : 8'h00;
    check("rx_ready", 8'(bus.rx_ready), 8'(!was_full));
    bus.port_id     = BASE;
    bus.read_strobe = do_pop;
    bus.rx_valid    = do_push;
    bus.rx_data     = d;
    if (do_pop) begin
      exp_rd_q.push_back(head);
      if (model_q.size() != 0) void'(model_q.pop_front());
    end
    if (do_push && !was_full) model_q.push_back(d);
    if (do_push && !was_full && model_irq_en) model_int = 1'b1;
    else if (bus.interrupt_ack)               model_int = 1'b0;
    tick();
    bus.read_strobe = 1'b0;
    bus.rx_valid    = 1'b0;
    check("irq", 8'(bus.interrupt), 8'(model_int));
    if (do_pop) check("rd_data", bus.in_port, exp_rd_q.pop_front());
  endtask

  task automatic read_status(input string tag, input logic [7:0] exp);
    bus.port_id = BASE + 8'd1;
    tick();
    check(tag, bus.in_port, exp);
    idle();
  endtask

  task automatic write_port(input logic [7:0] addr, input logic [7:0] v);
    bus.port_id      = addr;
    bus.out_port     = v;
    bus.write_strobe = 1'b1;
    tick();
    idle();
  endtask

  task automatic write_ctrl(input logic [7:0] v);
    write_port(BASE + 8'd1, v);
    model_irq_en = v[0];
    if (v[1]) model_q.delete();
  endtask

  task automatic drain();
    while (model_q.size() != 0) cycle(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    idle();
    bus.tx_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    check("rst_in_port",  bus.in_port, 8'h00);
    check("rst_irq",      8'(bus.interrupt), 8'h00);
    check("rst_rx_ready", 8'(bus.rx_ready), 8'h01);
    check("rst_tx_valid", 8'(bus.tx_valid), 8'h00);
    check("rst_tx_data",  bus.tx_data, 8'h00);
    read_status("rst_status", 8'h01);

    // Two pushes, two reads, then status shows empty
    cycle(1'b1, 8'hA5, 1'b0);
    cycle(1'b1, 8'h3C, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    read_status("status_empty", 8'h01);

    // Pop of an empty FIFO returns zero and changes nothing
    cycle(1'b0, 8'h00, 1'b1);
    read_status("status_empty2", 8'h01);

    // Fill to 16, refused 17th, one pop reopens rx_ready
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i * 7 + 1), 1'b0);
    check("full_rx_ready", 8'(bus.rx_ready), 8'h00);
    read_status("status_full", 8'h02);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    check("pop_rx_ready", 8'(bus.rx_ready), 8'h01);
    drain();

    // Push and pop together on non-empty, then on empty
    cycle(1'b1, 8'h11, 1'b0);
    cycle(1'b1, 8'h22, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h33, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    read_status("status_pp", 8'h01);

    // Strobes outside BASE..BASE+2 have no effect
    cycle(1'b1, 8'h5E, 1'b0);
    bus.port_id      = BASE + 8'd3;
    bus.read_strobe  = 1'b1;
    bus.write_strobe = 1'b1;
    bus.out_port     = 8'hFF;
    tick();
    idle();
    check("stray_in_port", bus.in_port, 8'h00);
    cycle(1'b1, 8'h6F, 1'b0);
    drain();

    // Interrupt: set after push, set wins over ack, ack alone clears
    write_ctrl(8'h01);
    cycle(1'b1, 8'h44, 1'b0);
    check("irq_set", 8'(bus.interrupt), 8'h01);
    bus.interrupt_ack = 1'b1;
    cycle(1'b1, 8'h55, 1'b0);
    check("irq_set_wins", 8'(bus.interrupt), 8'h01);
    cycle(1'b0, 8'h00, 1'b0);
    check("irq_ack", 8'(bus.interrupt), 8'h00);
    bus.interrupt_ack = 1'b0;

    // Flush with 5 entries and a concurrent push
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'h60 + i), 1'b0);
    bus.interrupt_ack = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    bus.interrupt_ack = 1'b0;
    bus.port_id      = BASE + 8'd1;
    bus.write_strobe = 1'b1;
    bus.out_port     = 8'h03;
    bus.rx_valid     = 1'b1;
    bus.rx_data      = 8'h99;
    tick();
    idle();
    model_q.delete();
    check("flush_irq", 8'(bus.interrupt), 8'h00);
    read_status("flush_status", 8'h01);
    cycle(1'b1, 8'h7A, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    write_ctrl(8'h00);
    bus.interrupt_ack = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    bus.interrupt_ack = 1'b0;

    // Random traffic exercising pointer wrap
    for (int i = 0; i < 150; i++)
      cycle($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 3);
    for (int i = 0; i < 150; i++)
      cycle($urandom_range(0, 9) < 3, 8'($urandom), $urandom_range(0, 9) < 7);
    drain();

`ifdef PICO_PORT_TX_EN
    // TX holding register: second write dropped, ready clears valid
    write_port(BASE + 8'd2, 8'h77);
    check("tx_valid_set", 8'(bus.tx_valid), 8'h01);
    check("tx_data_77",   bus.tx_data, 8'h77);
    write_port(BASE + 8'd2, 8'h88);
    check("tx_drop_data", bus.tx_data, 8'h77);
    check("tx_drop_vld",  8'(bus.tx_valid), 8'h01);
    read_status("tx_status", 8'h09);
    bus.tx_ready = 1'b1;
    tick();
    check("tx_accept_vld",  8'(bus.tx_valid), 8'h00);
    check("tx_accept_hold", bus.tx_data, 8'h77);
    write_port(BASE + 8'd2, 8'hAB);
    check("tx_reload_vld",  8'(bus.tx_valid), 8'h01);
    check("tx_reload_data", bus.tx_data, 8'hAB);
    tick();
    check("tx_reload_acc",  8'(bus.tx_valid), 8'h00);
    bus.tx_ready = 1'b0;
`else
    // Disabled TX path ignores BASE+2 writes
    write_port(BASE + 8'd2, 8'h77);
    check("notx_valid",  8'(bus.tx_valid), 8'h00);
    check("notx_data",   bus.tx_data, 8'h00);
    read_status("notx_status", 8'h01);
`endif

    // Reset mid-operation with entries, pending TX and interrupt
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0);
`ifdef PICO_PORT_TX_EN
    write_port(BASE + 8'd2, 8'h5A);
    check("pre_rst_tx", 8'(bus.tx_valid), 8'h01);
`endif
    write_ctrl(8'h01);
    cycle(1'b1, 8'hB3, 1'b0);
    check("pre_rst_irq", 8'(bus.interrupt), 8'h01);
    reset            = 1'b1;
    bus.rx_valid     = 1'b1;
    bus.rx_data      = 8'hC3;
    bus.port_id      = BASE + 8'd2;
    bus.write_strobe = 1'b1;
    bus.out_port     = 8'h11;
    tick();
    reset = 1'b0;
    idle();
    model_q.delete();
    model_irq_en = 1'b0;
    model_int    = 1'b0;
    check("mid_rst_in_port",  bus.in_port, 8'h00);
    check("mid_rst_rx_ready", 8'(bus.rx_ready), 8'h01);
    check("mid_rst_irq",      8'(bus.interrupt), 8'h00);
    check("mid_rst_tx_valid", 8'(bus.tx_valid), 8'h00);
    check("mid_rst_tx_data",  bus.tx_data, 8'h00);
    read_status("mid_rst_status", 8'h01);
    cycle(1'b1, 8'hD4, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
